shift_add_multiplier_ext: RTL
=============================

# shift_add_multiplier_ext

Parametrised sequential shift-add multiplier, successor of the 8-bit shift-add multiplier. Computes A×B one multiplier bit per clock, adding a per-operation signed (two's complement) mode and a multiply-accumulate mode, with overflow flagging, a completion pulse and defined reset behaviour. Sits in the datapath as a multi-cycle arithmetic unit driven by a start/ready handshake.

## Interface

- WIDTH, 8, operand width in bits; product width is 2×WIDTH; legal range 2–32.
- clock  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while idle (ready=1).
- signed_mode  in  1  1 = A, B and P are two's complement; 0 = unsigned; sampled with start.
- accumulate  in  1  1 = result is A×B + current P; 0 = result is A×B; sampled with start.
- A  in  WIDTH  multiplicand, sampled with start.
- B  in  WIDTH  multiplier, sampled with start.
- P  out  2×WIDTH  registered result; holds the last completed result.
- ready  out  1  1 = idle, can accept start; 0 = busy.
- done  out  1  one-cycle pulse on the cycle a new P appears.
- overflow  out  1  accumulate overflow of the last completed operation.

## Operation

- States: IDLE, RUN, FINISH.
- IDLE: ready=1. On an edge with start=1: capture A, B, signed_mode, accumulate; clear internal partial product and bit counter; go to RUN; ready=0.
- Signed capture: operands are converted to magnitude (WIDTH-bit unsigned; −2^(WIDTH−1) becomes 2^(WIDTH−1)); negate flag = sign(A) XOR sign(B). Unsigned mode: negate flag = 0.
- RUN: each edge, if current multiplier LSB = 1, add shifted multiplicand to internal partial product; shift multiplier right; increment counter. After WIDTH iterations, go to FINISH.
- FINISH (one edge): final = negate ? −partial : partial (2×WIDTH bits). If accumulate: P ← final + P (modulo 2^(2×WIDTH)), else P ← final. Set overflow, assert done, ready=1, go to IDLE.
- Overflow: accumulate=0 → 0. Unsigned accumulate → carry out of the 2×WIDTH-bit add. Signed accumulate → both addends same sign and sum sign differs.
- P, overflow change only in FINISH; internal partial product is separate, so P is stable throughout RUN.
- start while busy: ignored, no queueing. Changes to A, B, modes during RUN have no effect.
- start held high across FINISH: the edge after completion (ready=1) starts a new operation; back-to-back operation legal.

## Timing

- Reset (asynchronous, immediate): P=0, ready=1, done=0, overflow=0, state IDLE, counter 0. Reset mid-operation aborts it; no done pulse; P reads 0.
- Edge 0: start sampled, ready falls after this edge.
- Edges 1…WIDTH: iterations.
- Edge WIDTH+1: P, overflow updated, ready rises, done high for exactly this one cycle.
- Latency start-sample to valid P: WIDTH+1 clocks (9 for WIDTH=8). Throughput: one result per WIDTH+2 clocks with start held high.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Unsigned, WIDTH=8: A=53, B=70, start for one cycle → ready low 9 cycles, then P=3710 (0x0E7E), done one-cycle pulse, overflow=0; P unchanged during RUN.
- Signed, WIDTH=8: A=−5 (0xFB), B=7 → P=0xFFDD (−35); A=−128, B=−128 → P=0x4000; A=−128, B=127 → P=0xC080 (−16256).
- Accumulate unsigned, WIDTH=8: 192×128 → P=0x6000; then accumulate 200×200 → P=0xFC40, overflow=0; then accumulate 255×255 → P=0xFA41, overflow=1.
- Busy protection: start pulse with A=27, B=81; during RUN drive start=1, A=13, B=66 → single result P=2187 (0x088B), one done pulse, then new operation only after ready=1.
- Reset mid-operation: assert reset_n=0 at iteration 4 of 50×50 → P=0, ready=1, done=0 immediately; new start of 20×112 after release → P=2240 (0x08C0) after 9 cycles.
- WIDTH=16 instance: A=B=0xFFFF unsigned → P=0xFFFE0001 after 17 cycles; signed → P=0x00000001.

Source files
------------

// File: rtl/shift_add_multiplier_ext_if.sv
// Handshake and data bundle for shift_add_multiplier_ext.
//   start, signed_mode, accumulate, A, B : requester -> multiplier
//   P, ready, done, overflow             : multiplier -> requester
// The master modport is the requester side, the slave modport the multiplier side.
interface shift_add_multiplier_ext_if #(
  parameter int unsigned WIDTH = 8
);
  logic                   start;
  logic                   signed_mode;
  logic                   accumulate;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic [2*WIDTH-1:0]     P;
  logic                   ready;
  logic                   done;
  logic                   overflow;

  modport master (
    output start, signed_mode, accumulate, A, B,
    input  P, ready, done, overflow
  );

  modport slave (
    input  start, signed_mode, accumulate, A, B,
    output P, ready, done, overflow
  );
endinterface

// File: rtl/shift_add_multiplier_ext.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with optional two's
// complement operands and multiply-accumulate into the result register.
// Ports:
//   clock    : system clock, rising-edge active
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of shift_add_multiplier_ext_if (start/modes/A/B in,
//              P/ready/done/overflow out, all outputs registered)
// Timing: start sampled on edge 0, iterations on edges 1..WIDTH, result on edge WIDTH+1.
module shift_add_multiplier_ext #(
  parameter int unsigned WIDTH = 8
) (
  input logic                     clock,
  input logic                     reset_n,
  shift_add_multiplier_ext_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    partial_q, partial_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negate_q, negate_d;
  logic             acc_q, acc_d;
  logic             sm_q, sm_d;
  logic [PW-1:0]    p_q, p_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    final_res;
  logic [PW:0]      sum;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    negate_d  = negate_q;
    acc_d     = acc_q;
    sm_d      = sm_q;
    p_d       = p_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    // Magnitudes: the most negative value maps onto 2^(WIDTH-1) as an unsigned number.
    a_mag = (bus.signed_mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag = (bus.signed_mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    final_res = negate_q ? -partial_q : partial_q;
    sum       = {1'b0, final_res} + {1'b0, p_q};

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d   = {{WIDTH{1'b0}}, a_mag};
          mplier_d  = b_mag;
          partial_d = '0;
          cnt_d     = '0;
          negate_d  = bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          acc_d     = bus.accumulate;
          sm_d      = bus.signed_mode;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (mplier_q[0]) begin
          partial_d = partial_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        p_d = acc_q ? sum[PW-1:0] : final_res;
        if (!acc_q) begin
          ovf_d = 1'b0;
        end else if (sm_q) begin
          // Signed overflow: equal-sign addends producing a sum of the other sign.
          ovf_d = (final_res[PW-1] == p_q[PW-1]) && (sum[PW-1] != final_res[PW-1]);
        end else begin
          ovf_d = sum[PW];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
      negate_q  <= 1'b0;
      acc_q     <= 1'b0;
      sm_q      <= 1'b0;
      p_q       <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
      negate_q  <= negate_d;
      acc_q     <= acc_d;
      sm_q      <= sm_d;
      p_q       <= p_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.P        = p_q;
  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule
